// File: rtl/lsu_mm_issue_ctrl_pkg.sv
// Shared types for the matmul tile issue controller.
//  - mm_state_e : controller FSM encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//  - mm_cmd_t   : packed 36-bit tile command as stored in the command queue
package lsu_mm_issue_ctrl_pkg;

    localparam int ADDR_W = 12;
    localparam int LEN_W  = 4;
    localparam int TAG_W  = 4;
    localparam int CMD_W  = 2 * ADDR_W + 2 * LEN_W + TAG_W;  // 36

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mm_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [LEN_W-1:0]  col_len;
        logic [LEN_W-1:0]  row_len;
        logic [ADDR_W-1:0] i_addr;
        logic [ADDR_W-1:0] w_addr;
    } mm_cmd_t;

endpackage

// File: rtl/lsu_mm_cmd_fifo.sv
// Small synchronous command FIFO.
//  clk, rst_n : clock, async active-low reset (pointers only)
//  push/wdata : write when push & ~full
//  pop/rdata  : rdata is the current head; pop advances when ~empty
//  full/empty : derived from registered pointers only
module lsu_mm_cmd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]   wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                   (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign rdata = mem[rptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[PTR_W-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/lsu_mm_issue_ctrl.sv
// Matmul tile issue controller. Queues tile commands, fires a one-cycle start
// pulse to the WRAM and IRAM mm ctrl buffers together, waits for both
// mxu_end levels (with timeout) and returns a tagged completion.
//  clk, rst_n            : clock, async active-low reset
//  lsu_mm_cmd_*          : command push (vld/rdy handshake)
//  lsu_mm_wbuff_ctrl_*   : WRAM buffer start pulse + fields
//  lsu_mm_ibuff_ctrl_*   : IRAM buffer start pulse + fields
//  lsu_mm_*buff_mxu_end  : end levels from the buffers (sticky per tile)
//  lsu_mm_done_*         : completion (vld/rdy handshake), tag and timeout err
//  lsu_mm_busy           : tile in flight or commands pending
module lsu_mm_issue_ctrl
    import lsu_mm_issue_ctrl_pkg::*;
#(
    parameter int CMD_DEPTH = 2,
    parameter int TIMEOUT   = 255,
    parameter int TMO_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_mm_cmd_vld,
    output logic        lsu_mm_cmd_rdy,
    input  logic [11:0] lsu_mm_cmd_w_addr,
    input  logic [11:0] lsu_mm_cmd_i_addr,
    input  logic [3:0]  lsu_mm_cmd_row_len,
    input  logic [3:0]  lsu_mm_cmd_col_len,
    input  logic [3:0]  lsu_mm_cmd_tag,
    output logic        lsu_mm_wbuff_ctrl_vld,
    output logic [3:0]  lsu_mm_wbuff_ctrl_row_len,
    output logic [3:0]  lsu_mm_wbuff_ctrl_col_len,
    output logic [11:0] lsu_mm_wbuff_ctrl_start_addr,
    output logic        lsu_mm_ibuff_ctrl_vld,
    output logic [3:0]  lsu_mm_ibuff_ctrl_row_len,
    output logic [3:0]  lsu_mm_ibuff_ctrl_col_len,
    output logic [11:0] lsu_mm_ibuff_ctrl_start_addr,
    input  logic        lsu_mm_wbuff_mxu_end,
    input  logic        lsu_mm_ibuff_mxu_end,
    output logic        lsu_mm_done_vld,
    input  logic        lsu_mm_done_rdy,
    output logic [3:0]  lsu_mm_done_tag,
    output logic        lsu_mm_done_err,
    output logic        lsu_mm_busy
);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    mm_state_e          state;
    mm_cmd_t            push_cmd, head;
    logic [CMD_W-1:0]   q_rdata;
    logic               q_full, q_empty, q_pop;
    logic               issue_next;
    logic               w_seen, i_seen, w_hit, i_hit;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [3:0]         tile_tag;

    logic               ctrl_vld;
    logic [3:0]         ctrl_row, ctrl_col;
    logic [11:0]        ctrl_w_addr, ctrl_i_addr;

    assign push_cmd = '{tag:     lsu_mm_cmd_tag,
                        col_len: lsu_mm_cmd_col_len,
                        row_len: lsu_mm_cmd_row_len,
                        i_addr:  lsu_mm_cmd_i_addr,
                        w_addr:  lsu_mm_cmd_w_addr};
    assign head     = q_rdata;

    // Head is consumed during the single ISSUE cycle.
    assign q_pop    = (state == ST_ISSUE);

    lsu_mm_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lsu_mm_cmd_vld & ~q_full),
        .wdata (push_cmd),
        .pop   (q_pop),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty)
    );

    // Ready depends only on registered pointers; a same-cycle pop does not
    // open up a slot.
    assign lsu_mm_cmd_rdy = ~q_full;
    assign lsu_mm_busy    = (state != ST_IDLE) | ~q_empty;

    // Enter ISSUE from IDLE, or straight from RESP on the accept cycle.
    // The head cannot change before ISSUE (pushes go to the tail), so the
    // ctrl fields are captured here and driven as registers.
    assign issue_next = !q_empty &&
                        ((state == ST_IDLE) || (state == ST_RESP && lsu_mm_done_rdy));

    // End levels only count in WAIT; earlier they still reflect the last tile.
    assign w_hit = w_seen | lsu_mm_wbuff_mxu_end;
    assign i_hit = i_seen | lsu_mm_ibuff_mxu_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            ctrl_vld        <= 1'b0;
            ctrl_row        <= '0;
            ctrl_col        <= '0;
            ctrl_w_addr     <= '0;
            ctrl_i_addr     <= '0;
            tile_tag        <= '0;
            w_seen          <= 1'b0;
            i_seen          <= 1'b0;
            tmo_cnt         <= '0;
            lsu_mm_done_vld <= 1'b0;
            lsu_mm_done_tag <= '0;
            lsu_mm_done_err <= 1'b0;
        end else begin
            if (issue_next) begin
                ctrl_vld    <= 1'b1;
                ctrl_row    <= head.row_len;
                ctrl_col    <= head.col_len;
                ctrl_w_addr <= head.w_addr;
                ctrl_i_addr <= head.i_addr;
                tile_tag    <= head.tag;
            end else begin
                ctrl_vld    <= 1'b0;
                ctrl_row    <= '0;
                ctrl_col    <= '0;
                ctrl_w_addr <= '0;
                ctrl_i_addr <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (issue_next) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    w_seen <= w_hit;
                    i_seen <= i_hit;
                    // Completion is checked before timeout so a pair that
                    // closes on the last WAIT cycle still reports success.
                    if (w_hit && i_hit) begin
                        state           <= ST_RESP;
                        lsu_mm_done_vld <= 1'b1;
                        lsu_mm_done_tag <= tile_tag;
                        lsu_mm_done_err <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state           <= ST_RESP;
                        lsu_mm_done_vld <= 1'b1;
                        lsu_mm_done_tag <= tile_tag;
                        lsu_mm_done_err <= 1'b1;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (lsu_mm_done_rdy) begin
                        lsu_mm_done_vld <= 1'b0;
                        lsu_mm_done_tag <= '0;
                        lsu_mm_done_err <= 1'b0;
                        w_seen          <= 1'b0;
                        i_seen          <= 1'b0;
                        tmo_cnt         <= '0;
                        state           <= issue_next ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign lsu_mm_wbuff_ctrl_vld        = ctrl_vld;
    assign lsu_mm_wbuff_ctrl_row_len    = ctrl_row;
    assign lsu_mm_wbuff_ctrl_col_len    = ctrl_col;
    assign lsu_mm_wbuff_ctrl_start_addr = ctrl_w_addr;
    assign lsu_mm_ibuff_ctrl_vld        = ctrl_vld;
    assign lsu_mm_ibuff_ctrl_row_len    = ctrl_row;
    assign lsu_mm_ibuff_ctrl_col_len    = ctrl_col;
    assign lsu_mm_ibuff_ctrl_start_addr = ctrl_i_addr;

endmodule

// File: tb/tb_lsu_mm_issue_ctrl.sv
`timescale 1ns/1ps
module tb_lsu_mm_issue_ctrl;
    localparam int DEPTH = 2;
    localparam int TMO   = 8;
    localparam int NEVER = 1000;

    logic        clk = 0, rst_n = 0;
    logic        cmd_vld = 0, cmd_rdy;
    logic [11:0] cmd_w = 0, cmd_i = 0;
    logic [3:0]  cmd_row = 0, cmd_col = 0, cmd_tag = 0;
    logic        wvld, ivld;
    logic [3:0]  wrow, wcol, irow, icol;
    logic [11:0] waddr, iaddr;
    logic        w_end = 0, i_end = 0;
    logic        done_vld, done_rdy = 0, done_err;
    logic [3:0]  done_tag;
    logic        busy;

    int checks = 0, failures = 0;
    int cyc = 0;

    typedef struct packed {
        logic [11:0] w;
        logic [11:0] i;
        logic [3:0]  row;
        logic [3:0]  col;
        logic [3:0]  tag;
    } tcmd_t;

    typedef struct {
        bit          issue_to;
        bit          pair_ok;
        bit          idle_zero;
        tcmd_t       got;
        int          issue_cyc;
        bit          done_to;
        int          lat;
        logic [3:0]  tag;
        logic        err;
        bit          held_ok;
        bit          no_reissue;
        int          acc_cyc;
    } obs_t;

    lsu_mm_issue_ctrl #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO), .TMO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_mm_cmd_vld(cmd_vld), .lsu_mm_cmd_rdy(cmd_rdy),
        .lsu_mm_cmd_w_addr(cmd_w), .lsu_mm_cmd_i_addr(cmd_i),
        .lsu_mm_cmd_row_len(cmd_row), .lsu_mm_cmd_col_len(cmd_col),
        .lsu_mm_cmd_tag(cmd_tag),
        .lsu_mm_wbuff_ctrl_vld(wvld), .lsu_mm_wbuff_ctrl_row_len(wrow),
        .lsu_mm_wbuff_ctrl_col_len(wcol), .lsu_mm_wbuff_ctrl_start_addr(waddr),
        .lsu_mm_ibuff_ctrl_vld(ivld), .lsu_mm_ibuff_ctrl_row_len(irow),
        .lsu_mm_ibuff_ctrl_col_len(icol), .lsu_mm_ibuff_ctrl_start_addr(iaddr),
        .lsu_mm_wbuff_mxu_end(w_end), .lsu_mm_ibuff_mxu_end(i_end),
        .lsu_mm_done_vld(done_vld), .lsu_mm_done_rdy(done_rdy),
        .lsu_mm_done_tag(done_tag), .lsu_mm_done_err(done_err),
        .lsu_mm_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: ends become visible at WAIT offsets dw/di (0 = first WAIT cycle).
    // Completion shows one cycle after the later end, or after TMO WAIT cycles.
    function automatic int exp_lat(input int dw, input int di);
        int m = (dw > di) ? dw : di;
        return (m > TMO - 1) ? TMO + 1 : m + 2;
    endfunction
    function automatic logic exp_err(input int dw, input int di);
        int m = (dw > di) ? dw : di;
        return (m > TMO - 1);
    endfunction

    function automatic tcmd_t rand_cmd();
        tcmd_t c;
        c.w = 12'($urandom); c.i = 12'($urandom);
        c.row = 4'($urandom); c.col = 4'($urandom); c.tag = 4'($urandom);
        return c;
    endfunction

    // Waits for ready, presents the command for exactly one accepting edge.
    task automatic push_cmd(input tcmd_t c, output bit to);
        to = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_rdy) begin
                cmd_vld = 1; cmd_w = c.w; cmd_i = c.i;
                cmd_row = c.row; cmd_col = c.col; cmd_tag = c.tag;
                to = 0;
                break;
            end
        end
        fork
            begin @(posedge clk); #1 cmd_vld = 0; end
        join_none
    endtask

    // Acts as both buffers for one tile: waits for the start pulse, raises the
    // end levels at the given WAIT offsets, holds done_rdy low for 'hold'
    // cycles, then accepts. Records observations only.
    task automatic drive_tile(input int dw, input int di, input int hold,
                              input bit stale, output obs_t o);
        int h = 0;
        o.issue_to = 1; o.pair_ok = 0; o.idle_zero = 1; o.got = '0;
        o.issue_cyc = 0; o.done_to = 1; o.lat = 0; o.tag = 0; o.err = 0;
        o.held_ok = 1; o.no_reissue = 1; o.acc_cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            done_rdy = 0;
            if (wvld || ivld) begin o.issue_to = 0; break; end
            if ({wrow, wcol, waddr, irow, icol, iaddr} != 0) o.idle_zero = 0;
        end
        if (o.issue_to) return;
        o.pair_ok   = (wvld === 1'b1) && (ivld === 1'b1) &&
                      (irow === wrow) && (icol === wcol);
        o.got.w     = waddr; o.got.i = iaddr; o.got.row = wrow; o.got.col = wcol;
        o.issue_cyc = cyc;
        if (!stale) begin w_end = 0; i_end = 0; end
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (wvld || ivld) o.no_reissue = 0;
            if (o.done_to) begin
                if (done_vld === 1'b1) begin
                    o.done_to = 0; o.lat = j + 1; o.tag = done_tag; o.err = done_err;
                end else begin
                    w_end = (j >= dw); i_end = (j >= di);
                end
            end
            if (!o.done_to) begin
                if (!(done_vld === 1'b1 && done_tag === o.tag && done_err === o.err))
                    o.held_ok = 0;
                if (h >= hold) begin done_rdy = 1; o.acc_cyc = cyc; break; end
                h++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({wvld, ivld, wrow, wcol, waddr, irow, icol, iaddr, done_vld, done_tag, done_err, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0",
                     {wvld, ivld, wrow, wcol, waddr, irow, icol, iaddr, done_vld, done_tag, done_err, busy});
        end
        checks++;
        if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL reset_cmd_rdy got=%b exp=1", cmd_rdy); end
        rst_n = 1;
    endtask

    task automatic test_single();
        tcmd_t c; bit to; obs_t o;
        c.w = 12'h040; c.i = 12'h100; c.row = 3; c.col = 3; c.tag = 5;
        push_cmd(c, to);
        @(negedge clk);
        checks++;
        if (to || busy !== 1'b1 || wvld !== 1'b0) begin
            failures++; $display("FAIL single_queued to=%0d busy=%b wvld=%b exp busy=1 wvld=0", to, busy, wvld);
        end
        drive_tile(2, 4, 0, 0, o);
        checks++;
        if (o.issue_to || !o.pair_ok || {o.got.w, o.got.i, o.got.row, o.got.col} !== {c.w, c.i, c.row, c.col}) begin
            failures++; $display("FAIL single_issue to=%0d pair=%0d got=%0h exp=%0h", o.issue_to, o.pair_ok,
                                 {o.got.w, o.got.i, o.got.row, o.got.col}, {c.w, c.i, c.row, c.col});
        end
        checks++;
        if (o.done_to || o.lat != 6 || o.tag !== 4'd5 || o.err !== 1'b0 || !o.no_reissue) begin
            failures++; $display("FAIL single_done lat=%0d tag=%0d err=%b pulse_ok=%0d exp lat=6 tag=5 err=0",
                                 o.lat, o.tag, o.err, o.no_reissue);
        end
    endtask

    task automatic test_stale();
        tcmd_t c = rand_cmd(); bit to; obs_t o;
        w_end = 1; i_end = 1;
        push_cmd(c, to);
        drive_tile(3, 5, 0, 1, o);
        checks++;
        if (to || o.issue_to || o.done_to || o.lat != exp_lat(3, 5) || o.err !== 1'b0 || o.tag !== c.tag) begin
            failures++; $display("FAIL stale_end lat=%0d err=%b tag=%0d exp lat=%0d err=0 tag=%0d",
                                 o.lat, o.err, o.tag, exp_lat(3, 5), c.tag);
        end
    endtask

    task automatic test_timeout();
        int dws[3] = '{1, TMO - 1, TMO};
        int dis[3] = '{NEVER, TMO - 1, 2};
        for (int t = 0; t < 3; t++) begin
            tcmd_t c = rand_cmd(); bit to; obs_t o;
            push_cmd(c, to);
            drive_tile(dws[t], dis[t], 0, 0, o);
            checks++;
            if (to || o.done_to || o.lat != exp_lat(dws[t], dis[t]) ||
                o.err !== exp_err(dws[t], dis[t]) || o.tag !== c.tag) begin
                failures++; $display("FAIL timeout_%0d lat=%0d err=%b tag=%0d exp lat=%0d err=%b tag=%0d", t,
                                     o.lat, o.err, o.tag, exp_lat(dws[t], dis[t]), exp_err(dws[t], dis[t]), c.tag);
            end
        end
    endtask

    task automatic test_backpressure();
        tcmd_t a = rand_cmd(), b = rand_cmd(); bit to1, to2; obs_t o1, o2;
        push_cmd(a, to1);
        push_cmd(b, to2);
        drive_tile(0, 1, 10, 0, o1);
        checks++;
        if (to1 || to2 || o1.done_to || !o1.held_ok || !o1.no_reissue || o1.tag !== a.tag) begin
            failures++; $display("FAIL backpressure_hold held=%0d no_issue=%0d tag=%0d exp held=1 no_issue=1 tag=%0d",
                                 o1.held_ok, o1.no_reissue, o1.tag, a.tag);
        end
        drive_tile(2, 0, 0, 0, o2);
        checks++;
        if (o2.issue_to || o2.issue_cyc - o1.acc_cyc != 1 || o2.tag !== b.tag || o2.lat != exp_lat(2, 0)) begin
            failures++; $display("FAIL backpressure_next gap=%0d tag=%0d lat=%0d exp gap=1 tag=%0d lat=%0d",
                                 o2.issue_cyc - o1.acc_cyc, o2.tag, o2.lat, b.tag, exp_lat(2, 0));
        end
    endtask

    task automatic test_back_to_back();
        tcmd_t cs[3];
        obs_t  ob[3];
        bit    saw_full = 0;
        for (int t = 0; t < 3; t++) begin cs[t] = rand_cmd(); cs[t].tag = 4'(t + 1); end
        fork
            begin
                int pushed = 0, issued = 0;
                bit exp_rdy;
                for (int k = 0; k < 30 && pushed < 3; k++) begin
                    @(negedge clk);
                    cmd_vld = 0;
                    exp_rdy = ((pushed - issued) < DEPTH);
                    checks++;
                    if (cmd_rdy !== exp_rdy) begin
                        failures++; $display("FAIL b2b_cmd_rdy k=%0d got=%b exp=%b", k, cmd_rdy, exp_rdy);
                    end
                    if (!exp_rdy) saw_full = 1;
                    if (wvld) issued++;
                    if (exp_rdy) begin
                        cmd_vld = 1; cmd_w = cs[pushed].w; cmd_i = cs[pushed].i;
                        cmd_row = cs[pushed].row; cmd_col = cs[pushed].col; cmd_tag = cs[pushed].tag;
                        pushed++;
                    end
                end
                @(posedge clk); #1 cmd_vld = 0;
            end
            begin
                for (int t = 0; t < 3; t++) drive_tile(t, 0, 0, 0, ob[t]);
            end
        join
        checks++;
        if (saw_full !== 1'b1) begin failures++; $display("FAIL b2b_full got=%b exp=1", saw_full); end
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (ob[t].issue_to || ob[t].done_to || ob[t].tag !== cs[t].tag || ob[t].err !== 1'b0 ||
                {ob[t].got.w, ob[t].got.i, ob[t].got.row, ob[t].got.col} !== {cs[t].w, cs[t].i, cs[t].row, cs[t].col} ||
                (t > 0 && ob[t].issue_cyc - ob[t-1].acc_cyc != 1)) begin
                failures++; $display("FAIL b2b_tile%0d tag=%0d err=%b gap=%0d exp tag=%0d err=0 gap=1", t,
                                     ob[t].tag, ob[t].err, (t > 0) ? ob[t].issue_cyc - ob[t-1].acc_cyc : 1, cs[t].tag);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            tcmd_t c = rand_cmd(); bit to; obs_t o;
            int dw   = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 10));
            int di   = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 10));
            int hold = $urandom_range(0, 3);
            bit st   = 1'($urandom);
            push_cmd(c, to);
            drive_tile(dw, di, hold, st, o);
            checks++;
            if (to || o.issue_to || !o.pair_ok || !o.idle_zero ||
                {o.got.w, o.got.i, o.got.row, o.got.col} !== {c.w, c.i, c.row, c.col}) begin
                failures++; $display("FAIL rand_issue_%0d pair=%0d idle0=%0d got=%0h exp=%0h", n, o.pair_ok,
                                     o.idle_zero, {o.got.w, o.got.i, o.got.row, o.got.col}, {c.w, c.i, c.row, c.col});
            end
            checks++;
            if (o.done_to || o.lat != exp_lat(dw, di) || o.err !== exp_err(dw, di) || o.tag !== c.tag ||
                !o.held_ok || !o.no_reissue) begin
                failures++; $display("FAIL rand_done_%0d dw=%0d di=%0d lat=%0d err=%b tag=%0d held=%0d exp lat=%0d err=%b tag=%0d",
                                     n, dw, di, o.lat, o.err, o.tag, o.held_ok, exp_lat(dw, di), exp_err(dw, di), c.tag);
            end
        end
    endtask

    task automatic test_reset_mid();
        tcmd_t a = rand_cmd(), b = rand_cmd(); bit to1, to2, seen = 0, quiet = 1;
        w_end = 0; i_end = 0;
        @(negedge clk); done_rdy = 0;
        push_cmd(a, to1);
        push_cmd(b, to2);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wvld) begin seen = 1; break; end
        end
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if (to1 || to2 || !seen ||
            {wvld, ivld, wrow, wcol, waddr, irow, icol, iaddr, done_vld, done_tag, done_err, busy} !== '0 ||
            cmd_rdy !== 1'b1) begin
            failures++; $display("FAIL reset_mid_outputs seen=%0d busy=%b rdy=%b wvld=%b done=%b exp busy=0 rdy=1 wvld=0 done=0",
                                 seen, busy, cmd_rdy, wvld, done_vld);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_vld || wvld || ivld || busy || !cmd_rdy) quiet = 0;
        end
        checks++;
        if (quiet !== 1'b1) begin failures++; $display("FAIL reset_mid_quiet got=%b exp=1", quiet); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stale();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
